// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the instruction fetch / prefetch block.
package arm_fetch_pkg;

    localparam int unsigned FE_ADDR_W = 32;
    localparam int unsigned FE_DATA_W = 32;

    // Instruction word returned for fetches beyond the end of the program memory.
    localparam logic [FE_DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [FE_DATA_W-1:0] instr;
        logic [FE_ADDR_W-1:0] pc;
        logic                 err;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_prefetch_if.sv
// Fetch-side bundle: fetch control, branch redirect, program-load port and decode handshake.
interface instr_fetch_prefetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              fetch_en;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              out_err;

    modport master (
        output fetch_en, redirect_valid, redirect_pc,
        output load_en, load_addr, load_data,
        output out_ready,
        input  out_valid, out_instr, out_pc, out_err
    );

    modport slave (
        input  fetch_en, redirect_valid, redirect_pc,
        input  load_en, load_addr, load_data,
        input  out_ready,
        output out_valid, out_instr, out_pc, out_err
    );
endinterface

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of fetch entries; the head entry is presented directly on head_o.
module fetch_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter type         entry_t    = arm_fetch_pkg::fetch_entry_t
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    input  entry_t                      wdata_i,
    output entry_t                      head_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer / occupancy update; flush dominates push and pop.
    always_comb begin
        do_push_s = push_i & ~flush_i;
        do_pop_s  = pop_i & ~flush_i & (count_q != '0);
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push_s) begin
                wptr_d = wptr_q + PTR_W'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (do_pop_s) begin
                rptr_d = rptr_q + PTR_W'(1);
            end else begin
                rptr_d = rptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; cleared on reset so the idle head reads as all-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_comb begin
        head_o  = mem_q[rptr_q];
        count_o = count_q;
        full_o  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
        empty_o = (count_q == '0);
    end

    fetch_fifo_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_i),
        .full_i  (full_o),
        .flush_i (flush_i)
    );
endmodule

// File: rtl/fetch_fifo_chk.sv
// Protocol checks for the prefetch queue.
module fetch_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push_i,
    input logic full_i,
    input logic flush_i
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full_i && !flush_i));
endmodule

// File: rtl/instr_fetch_prefetch.sv
// Program memory with sequential prefetch into a small queue drained by decode;
// a branch redirect flushes queued and in-flight words and restarts at the new PC.
module instr_fetch_prefetch
    import arm_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = FE_ADDR_W,
    parameter int unsigned       DATA_W     = FE_DATA_W,
    parameter int unsigned       DEPTH      = 1024,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] NOP        = NOP_INSTR
) (
    input logic                    clk,
    input logic                    rst_n,
    instr_fetch_prefetch_if.slave  fetch_if
);
    localparam int unsigned       IDX_W     = $clog2(DEPTH);
    localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(DEPTH * 4);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        logic              err;
    } entry_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
    logic              tag_err_q, tag_err_d;
    logic              inflight_q, inflight_d;
    fetch_state_e      state_q, state_d;

    logic              issue_s, push_s, pop_s, flush_s, credit_s;
    logic              pc_oor_s, load_ok_s;
    logic [IDX_W-1:0]  rd_idx_s, wr_idx_s;
    entry_t            push_entry_s, head_s;
    logic              full_s, empty_s;
    logic [CNT_W-1:0]  q_count_s;

    // Issue credit: queued plus in-flight words must leave room; same-cycle pops are not counted.
    always_comb begin
        credit_s = ~full_s &
                   (((CNT_W+1)'(q_count_s) + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(FIFO_DEPTH));
    end

    // Control FSM: a redirect forces S_FLUSH and suppresses issue in that cycle.
    always_comb begin
        state_d = state_q;
        flush_s = 1'b0;
        issue_s = 1'b0;
        case (state_q)
            S_RUN, S_FLUSH: begin
                if (fetch_if.redirect_valid) begin
                    state_d = S_FLUSH;
                    flush_s = 1'b1;
                end else begin
                    state_d = S_RUN;
                    issue_s = fetch_if.fetch_en & credit_s;
                end
            end
            default: begin
                state_d = S_RUN;
                flush_s = 1'b1;
            end
        endcase
    end

    // PC, in-flight tag and queue-side datapath.
    always_comb begin
        pc_oor_s  = (pc_q >= MEM_BYTES);
        rd_idx_s  = pc_q[IDX_W+1:2];
        wr_idx_s  = fetch_if.load_addr[IDX_W+1:2];
        load_ok_s = fetch_if.load_en & (fetch_if.load_addr < MEM_BYTES);
        push_s    = inflight_q & ~flush_s;
        pop_s     = ~empty_s & fetch_if.out_ready;
        pc_d      = pc_q;
        tag_pc_d  = tag_pc_q;
        tag_err_d = tag_err_q;
        // Every issued read is pushed (or killed) on the following edge, so the flag just follows issue.
        inflight_d = issue_s;
        if (flush_s) begin
            pc_d = fetch_if.redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
        end else if (issue_s) begin
            pc_d = pc_q + ADDR_W'(4);
        end else begin
            pc_d = pc_q;
        end
        if (issue_s) begin
            tag_pc_d  = pc_q;
            tag_err_d = pc_oor_s;
        end else begin
            tag_pc_d  = tag_pc_q;
            tag_err_d = tag_err_q;
        end
        push_entry_s.instr = tag_err_q ? NOP : rdata_q;
        push_entry_s.pc    = tag_pc_q;
        push_entry_s.err   = tag_err_q;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            pc_q       <= '0;
            tag_pc_q   <= '0;
            tag_err_q  <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_pc_q   <= tag_pc_d;
            tag_err_q  <= tag_err_d;
            inflight_q <= inflight_d;
        end
    end

    // Program memory: synchronous read-before-write, contents survive reset.
    always_ff @(posedge clk) begin
        if (issue_s && !pc_oor_s) begin
            rdata_q <= mem_q[rd_idx_s];
        end
        if (load_ok_s) begin
            mem_q[wr_idx_s] <= fetch_if.load_data;
        end
    end

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .entry_t    (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (flush_s),
        .wdata_i (push_entry_s),
        .head_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (q_count_s)
    );

    // Decode-facing outputs come straight from the queue head registers.
    always_comb begin
        fetch_if.out_valid = ~empty_s;
        fetch_if.out_instr = head_s.instr;
        fetch_if.out_pc    = head_s.pc;
        fetch_if.out_err   = head_s.err;
    end
endmodule

// File: tb/tb_instr_fetch_prefetch.sv
// Directed and randomized checks of instr_fetch_prefetch against an in-order PC stream model.
module tb_instr_fetch_prefetch;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DEPTH      = 1024;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [31:0] NOP_W      = 32'h0000_0000;
    localparam logic [31:0] TOP_BYTES  = 32'(DEPTH * 4);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_fetch_prefetch #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .FIFO_DEPTH(FIFO_DEPTH), .NOP(NOP_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetch_if (bus)
    );

    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_pc;
    int          compared   = 0;
    int          mismatched = 0;

    function automatic logic [31:0] model_instr(input logic [31:0] pc);
        if (pc >= TOP_BYTES) return NOP_W;
        return mem_m[pc >> 2];
    endfunction

    function automatic logic model_err(input logic [31:0] pc);
        return (pc >= TOP_BYTES);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Score the handshake that the coming edge will perform, then advance one cycle.
    task automatic cycle_check(input string tag);
        if (bus.out_valid && bus.out_ready) begin
            chk({tag, "_pc"},    bus.out_pc,    exp_pc);
            chk({tag, "_instr"}, bus.out_instr, model_instr(exp_pc));
            chk({tag, "_err"},   bus.out_err,   model_err(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        if (bus.redirect_valid) exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        tick();
    endtask

    initial begin
        logic [31:0] old8, new8, rpc;
        int          waited;

        rst_n              = 1'b0;
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.load_en        = 1'b0;
        bus.load_addr      = 32'h0;
        bus.load_data      = 32'h0;
        bus.out_ready      = 1'b0;
        exp_pc             = 32'h0;
        tick();

        // Program image loaded while held in reset.
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = $urandom;
        mem_m[0] = 32'hE3A0_0014;
        mem_m[1] = 32'hE3A0_1A01;
        mem_m[2] = 32'hE3A0_2103;
        mem_m[3] = 32'hE092_3002;
        bus.load_en = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus.load_addr = 32'(i * 4);
            bus.load_data = mem_m[i];
            tick();
        end
        bus.load_addr = TOP_BYTES;
        bus.load_data = 32'hDEAD_BEEF;
        tick();
        bus.load_en = 1'b0;

        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_instr", bus.out_instr, 32'h0);
        chk("rst_pc",    bus.out_pc,    32'h0);
        chk("rst_err",   bus.out_err,   1'b0);

        // Test 1: latency and first four words.
        rst_n = 1'b1; bus.fetch_en = 1'b1; bus.out_ready = 1'b1; exp_pc = 32'h0;
        tick();
        chk("t1_lat1", bus.out_valid, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", bus.out_valid, 1'b1);
            cycle_check("t1");
        end

        // Test 2: back-pressure fills exactly FIFO_DEPTH entries, then drains without gaps.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t2_head", bus.out_pc, exp_pc);
            cycle_check("t2");
        end
        chk("t2_qcount",   dut.q_count_s,  FIFO_DEPTH);
        chk("t2_inflight", dut.inflight_q, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_valid", bus.out_valid, 1'b1);
            cycle_check("t2");
        end

        // Test 3: mid-stream redirect to an unaligned PC.
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h43;
        cycle_check("t3");
        bus.redirect_valid = 1'b0;
        chk("t3_flush1", bus.out_valid, 1'b0);
        cycle_check("t3");
        chk("t3_flush2", bus.out_valid, 1'b0);
        cycle_check("t3");
        chk("t3_lat", bus.out_valid, 1'b1);
        chk("t3_pc",  bus.out_pc,    32'h40);
        for (int i = 0; i < 4; i++) cycle_check("t3");

        // Test 4: last valid word then the first out-of-range word.
        bus.redirect_valid = 1'b1; bus.redirect_pc = TOP_BYTES - 32'd4;
        cycle_check("t4");
        bus.redirect_valid = 1'b0;
        cycle_check("t4");
        cycle_check("t4");
        chk("t4_last_valid", bus.out_valid, 1'b1);
        chk("t4_last_err",   bus.out_err,   1'b0);
        cycle_check("t4");
        chk("t4_oor_err",   bus.out_err,   1'b1);
        chk("t4_oor_instr", bus.out_instr, NOP_W);
        chk("t4_oor_pc",    bus.out_pc,    TOP_BYTES);
        cycle_check("t4");

        // Test 5: load colliding with the fetch of the same word is read-before-write.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; exp_pc = 32'h0;
        old8 = mem_m[2];
        new8 = old8 ^ 32'h5A5A_0001;
        tick();
        tick();
        bus.load_en = 1'b1; bus.load_addr = 32'h8; bus.load_data = new8;
        cycle_check("t5");
        bus.load_en = 1'b0;
        cycle_check("t5");
        chk("t5_old", bus.out_instr, old8);
        cycle_check("t5");
        mem_m[2] = new8;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8;
        cycle_check("t5");
        bus.redirect_valid = 1'b0;
        cycle_check("t5");
        cycle_check("t5");
        chk("t5_new", bus.out_instr, new8);
        cycle_check("t5");

        // Test 6: asynchronous reset with queued entries and a read in flight.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; bus.out_ready = 1'b0; exp_pc = 32'h0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_qcount",   dut.q_count_s,  3);
        chk("t6_inflight", dut.inflight_q, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", bus.out_valid, 1'b0);
        chk("t6_async_pc",    bus.out_pc,    32'h0);
        tick();
        rst_n = 1'b1; bus.out_ready = 1'b1; exp_pc = 32'h0;
        tick();
        tick();
        chk("t6_restart_valid", bus.out_valid, 1'b1);
        chk("t6_restart_pc",    bus.out_pc,    32'h0);

        // Randomized traffic: gated fetch, random back-pressure and redirects.
        for (int i = 0; i < 400; i++) begin
            bus.fetch_en       = ($urandom_range(9) != 0);
            bus.out_ready      = ($urandom_range(9) < 6);
            bus.redirect_valid = ($urandom_range(19) == 0);
            case ($urandom_range(3))
                0:       rpc = 32'($urandom_range(DEPTH * 4 - 1));
                1:       rpc = TOP_BYTES - 32'd16 + 32'($urandom_range(31));
                default: rpc = 32'($urandom_range(63));
            endcase
            bus.redirect_pc = rpc;
            cycle_check("rnd");
        end

        bus.redirect_valid = 1'b0; bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
        waited = 0;
        while (!bus.out_valid && waited < 8) begin
            cycle_check("rnd");
            waited++;
        end
        chk("rnd_live", bus.out_valid, 1'b1);
        for (int i = 0; i < 6; i++) cycle_check("rnd_tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
